sample_frame_buffer: RTL and testbench
======================================

SAMPLE_FRAME_BUFFER -- requirements
Module: sample_frame_buffer

Interface
REQ-001 SHALL have parameter DATA_W, 16, sample width in bits.
REQ-002 SHALL have parameter DEPTH, 16, samples per frame; power of two, 4..256.
REQ-003 SHALL have parameter HOP, 16, new samples between frames after first fill; 1..DEPTH.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush  input  1  synchronous restart of frame assembly.
REQ-007 SHALL have port in_valid  input  1  in_data holds a sample.
REQ-008 SHALL have port in_ready  output  1  sample is accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port in_data  input  DATA_W  sample value.
REQ-010 SHALL have port frame_valid  output  1  frame_data holds a complete frame.
REQ-011 SHALL have port frame_ready  input  1  consumer takes the frame when frame_valid and frame_ready are both high.
REQ-012 SHALL have port frame_data  output  DEPTH*DATA_W  slot k occupies bits [k*DATA_W +: DATA_W].
REQ-013 SHALL have port frame_cnt  output  16  count of frames issued; wraps modulo 2^16.

Function
REQ-014 SHALL hold samples in a DEPTH-entry shift line; each accepted sample shifts mem[i] <= mem[i+1] and loads mem[DEPTH-1] <= in_data; entry 0 is the oldest sample.
REQ-015 SHALL implement states FILL and RUN; FILL counts accepted samples to DEPTH, then the state moves to RUN; RUN counts accepted samples to HOP.
REQ-016 SHALL trigger a frame on the accept that reaches DEPTH in FILL or HOP in RUN; the trigger clears the hop counter.
REQ-017 SHALL, on a trigger, load frame_data with a snapshot that includes the triggering sample and raise frame_valid on the next cycle (latency 1).
REQ-018 SHALL hold frame_data and frame_valid stable until the frame is taken; frame_valid falls the cycle after the take unless a new frame is loaded in that same cycle.
REQ-019 SHALL drive in_ready low only when frame_valid=1, frame_ready=0, and the next accept would trigger a frame; no frame is ever dropped or overwritten.
REQ-020 SHALL, when a frame is taken and a trigger occur in the same cycle, load the new snapshot with frame_valid remaining 1.
REQ-021 SHALL increment frame_cnt by 1 on each trigger.
REQ-022 SHALL treat flush as dominant over an accept in the same cycle.
REQ-023 SHALL, on flush, clear the counters and frame_valid, return to FILL, and retain mem and frame_cnt; the next frame needs DEPTH new samples.
REQ-024 SHALL, when HOP=DEPTH, produce non-overlapping frames; when HOP<DEPTH, consecutive frames overlap by DEPTH-HOP samples.

Reset
REQ-025 SHALL, while rst=1, clear mem, frame_data, frame_cnt, the counters and frame_valid to 0, set the state to FILL, and hold in_ready=1.
REQ-026 SHALL, on reset mid-frame, discard any pending frame; no frame_valid appears after release until DEPTH accepts.

Configuration
REQ-027 SHALL, with BITREV_OUT_EN defined, place mem[bitrev(k)] in frame_data slot k, where bitrev reverses the log2(DEPTH)-bit index (decimation-in-time FFT input order).
REQ-028 SHALL, without BITREV_OUT_EN, place mem[k] in slot k (natural order).
REQ-029 SHALL apply the ordering only at snapshot load; handshake timing is identical in both builds.

Structure
REQ-030 SHALL keep the default DATA_W/DEPTH values, the state enum, and the bit-reverse index function in shared package fft_pkg.
REQ-031 SHALL implement the hop/fill counter and state logic as sub-module frame_sequencer; the shift line and snapshot stay in the top level.

Verification
REQ-032 SHALL check: DEPTH=16, HOP=16, samples 1..16 streamed back-to-back with frame_ready=1 -> one cycle after sample 16, frame_valid=1 and slot0=1, slot15=16, frame_cnt=1.
REQ-033 SHALL check: HOP=4, samples 1..24 streamed -> frames end on samples 16, 20, 24; the second frame has slot0=5 and slot15=20.
REQ-034 SHALL check: HOP=1, frame_ready=0 after the first frame -> in_ready=0 with the first frame held intact; raising frame_ready gives exactly one take, then the next frame carries slot0=2.
REQ-035 SHALL check: flush asserted after sample 10 together with in_valid=1 -> that sample is not accepted, no frame appears, and the next frame is issued after 16 further samples.
REQ-036 SHALL check: BITREV_OUT_EN defined, samples 0..15 -> slot1=8, slot2=4, slot3=12, slot15=15.
REQ-037 SHALL check: rst pulsed during FILL at sample 7 -> all outputs 0 at once and frame_cnt=0; a frame follows only after 16 new samples.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg -- shared definitions for the sample frame buffer.
//   DATA_W_DEF / DEPTH_DEF : default sample width and frame length
//   seq_state_t            : frame sequencer states (FILL, RUN)
//   bitrev()               : reverses the low 'bits' bits of an index, giving
//                            the decimation-in-time FFT input order
package fft_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 16;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  function automatic int unsigned bitrev(input int unsigned idx, input int unsigned bits);
    int unsigned r;
    r = 0;
    for (int unsigned b = 0; b < bits; b++) begin
      r = (r << 1) | ((idx >> b) & 32'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/sample_frame_buffer_if.sv
// sample_frame_buffer_if -- sample input stream and frame output bundle.
//   flush       : synchronous restart of frame assembly (producer side)
//   in_valid    : in_data holds a sample
//   in_ready    : buffer can take the sample this cycle
//   in_data     : sample value
//   frame_valid : frame_data holds a complete frame
//   frame_ready : consumer takes the frame this cycle
//   frame_data  : DEPTH slots, slot k at [k*DATA_W +: DATA_W]
//   frame_cnt   : frames issued, modulo 2^16
// Modports: slave = buffer side, master = producer/consumer side.
interface sample_frame_buffer_if #(
  parameter int DATA_W = fft_pkg::DATA_W_DEF,
  parameter int DEPTH  = fft_pkg::DEPTH_DEF
);

  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_W-1:0]       in_data;
  logic                    frame_valid;
  logic                    frame_ready;
  logic [DEPTH*DATA_W-1:0] frame_data;
  logic [15:0]             frame_cnt;

  modport slave (
    input  flush, in_valid, in_data, frame_ready,
    output in_ready, frame_valid, frame_data, frame_cnt
  );

  modport master (
    output flush, in_valid, in_data, frame_ready,
    input  in_ready, frame_valid, frame_data, frame_cnt
  );

endinterface

// File: rtl/sample_frame_buffer_sequencer.sv
// frame_sequencer -- fill/hop counting and frame trigger generation.
//   clk, rst  : clock and asynchronous active-high reset
//   flush     : restart assembly; dominates an accept in the same cycle
//   accept    : a sample is accepted this cycle (valid & ready)
//   arm       : the next accept would trigger a frame
//   trigger   : this cycle's accept completes a frame
//   frame_cnt : frames triggered so far (kept across flush)
module frame_sequencer import fft_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int HOP   = DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        accept,
  output logic        arm,
  output logic        trigger,
  output logic [15:0] frame_cnt
);

  // Counts never exceed DEPTH-1 because the trigger clears them.
  localparam int CNT_W = $clog2(DEPTH);

  seq_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [15:0]      frame_cnt_reg;

  // First frame needs a full line; later frames need HOP new samples.
  always_comb begin
    arm = 1'b0;
    if (state_reg == FILL) begin
      arm = (cnt_reg == CNT_W'(DEPTH - 1));
    end else begin
      arm = (cnt_reg == CNT_W'(HOP - 1));
    end
  end

  assign trigger   = accept & ~flush & arm;
  assign frame_cnt = frame_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= FILL;
      cnt_reg       <= '0;
      frame_cnt_reg <= '0;
    end else if (flush) begin
      state_reg <= FILL;
      cnt_reg   <= '0;
    end else if (accept) begin
      if (arm) begin
        state_reg     <= RUN;
        cnt_reg       <= '0;
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sample_frame_buffer.sv
// sample_frame_buffer -- assembles a stream of samples into (optionally
// overlapping) frames of DEPTH samples, issued every HOP samples after the
// first full line.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : sample_frame_buffer_if.slave (input stream, frame output, flush)
// Build option: define BITREV_OUT_EN to emit frames in bit-reversed slot order
// (slot k = line[bitrev(k)]); otherwise slot k = line[k]. Handshake timing is
// the same in both builds.
module sample_frame_buffer import fft_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int HOP    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sample_frame_buffer_if.slave bus
);

  logic [DATA_W-1:0]       mem       [DEPTH];
  logic [DATA_W-1:0]       line_next [DEPTH];
  logic [DEPTH*DATA_W-1:0] snap;
  logic [DEPTH*DATA_W-1:0] frame_data_reg;
  logic                    frame_valid_reg;
  logic                    accept;
  logic                    shift;
  logic                    arm;
  logic                    trigger;
  logic                    take;
  logic [15:0]             frame_cnt;

  assign accept = bus.in_valid & bus.in_ready;
  assign shift  = accept & ~bus.flush;
  assign take   = frame_valid_reg & bus.frame_ready;

  // Stall only when accepting would create a frame with nowhere to put it;
  // a take in the same cycle frees the output register.
  assign bus.in_ready = ~(frame_valid_reg & ~bus.frame_ready & arm);

  frame_sequencer #(
    .DEPTH (DEPTH),
    .HOP   (HOP)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.flush),
    .accept    (accept),
    .arm       (arm),
    .trigger   (trigger),
    .frame_cnt (frame_cnt)
  );

  // Line contents after this cycle's shift, so the snapshot includes the
  // triggering sample.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_line
      if (gi == DEPTH - 1) begin : g_tail
        assign line_next[gi] = bus.in_data;
      end else begin : g_body
        assign line_next[gi] = mem[gi+1];
      end
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
`ifdef BITREV_OUT_EN
      localparam int SRC = int'(bitrev(gi, $clog2(DEPTH)));
`else
      localparam int SRC = gi;
`endif
      assign snap[gi*DATA_W +: DATA_W] = line_next[SRC];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (shift) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= line_next[i];
      end
    end
  end

  // Trigger has priority over take so a take+trigger cycle keeps valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_data_reg  <= '0;
      frame_valid_reg <= 1'b0;
    end else if (bus.flush) begin
      frame_valid_reg <= 1'b0;
    end else if (trigger) begin
      frame_data_reg  <= snap;
      frame_valid_reg <= 1'b1;
    end else if (take) begin
      frame_valid_reg <= 1'b0;
    end
  end

  assign bus.frame_valid = frame_valid_reg;
  assign bus.frame_data  = frame_data_reg;
  assign bus.frame_cnt   = frame_cnt;

endmodule

// File: tb/tb_sample_frame_buffer.sv
// tb_sample_frame_buffer -- scoreboard bench for sample_frame_buffer.
// Three instances (HOP = 16, 4, 1) share clk/rst; one is exercised at a time.
// Expected frames are pushed when a sample is accepted and popped when the
// DUT hands a frame over.
module tb_sample_frame_buffer;

  localparam int DW = 16;
  localparam int DP = 16;
  localparam int FW = DW * DP;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          flush_s       [NI];
  logic          in_valid_s    [NI];
  logic          in_ready_s    [NI];
  logic [DW-1:0] in_data_s     [NI];
  logic          frame_valid_s [NI];
  logic          frame_ready_s [NI];
  logic [FW-1:0] frame_data_s  [NI];
  logic [15:0]   frame_cnt_s   [NI];

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int HOP_G = (gi == 0) ? 16 : (gi == 1) ? 4 : 1;
      sample_frame_buffer_if #(.DATA_W(DW), .DEPTH(DP)) bus ();
      assign bus.flush        = flush_s[gi];
      assign bus.in_valid     = in_valid_s[gi];
      assign bus.in_data      = in_data_s[gi];
      assign bus.frame_ready  = frame_ready_s[gi];
      assign in_ready_s[gi]    = bus.in_ready;
      assign frame_valid_s[gi] = bus.frame_valid;
      assign frame_data_s[gi]  = bus.frame_data;
      assign frame_cnt_s[gi]   = bus.frame_cnt;
      sample_frame_buffer #(.DATA_W(DW), .DEPTH(DP), .HOP(HOP_G)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
      );
    end
  endgenerate

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [FW-1:0] data;
    logic [15:0]   cnt;
  } frame_t;

  frame_t      exp_q[$];
  int          hist[$];
  int          act;
  int          mdl_n;
  int          mdl_hop;
  bit          mdl_filled;
  logic [15:0] mdl_cnt;

  function automatic int order(input int k);
`ifdef BITREV_OUT_EN
    int r = 0;
    for (int b = 0; b < 4; b++) if (k[b]) r = r + (1 << (3 - b));
    return r;
`else
    return k;
`endif
  endfunction

  function automatic logic [DW-1:0] slot(input logic [FW-1:0] v, input int k);
    return v[k*DW +: DW];
  endfunction

  task automatic model_init(input int hop);
    hist = {};
    for (int i = 0; i < DP; i++) hist.push_back(0);
    mdl_n = 0; mdl_filled = 0; mdl_cnt = 0; mdl_hop = hop;
    exp_q.delete();
  endtask

  task automatic model_flush();
    mdl_n = 0; mdl_filled = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input int v);
    frame_t f;
    hist.push_back(v);
    void'(hist.pop_front());
    mdl_n++;
    if ((!mdl_filled && mdl_n == DP) || (mdl_filled && mdl_n == mdl_hop)) begin
      mdl_filled = 1; mdl_n = 0; mdl_cnt++;
      for (int k = 0; k < DP; k++) f.data[k*DW +: DW] = DW'(hist[order(k)]);
      f.cnt = mdl_cnt;
      exp_q.push_back(f);
    end
  endtask

  // Frame handed over at the coming edge: compare against the scoreboard.
  always @(negedge clk) begin
    if (!rst && frame_valid_s[act] && frame_ready_s[act]) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", FW'(frame_valid_s[act]), '0);
      end else begin
        frame_t f;
        f = exp_q.pop_front();
        $display("inst %0d frame %0d taken slot0=%0d slot15=%0d", act, frame_cnt_s[act],
                 slot(frame_data_s[act], 0), slot(frame_data_s[act], DP-1));
        check("frame_data", frame_data_s[act], f.data);
        check("frame_cnt", FW'(frame_cnt_s[act]), FW'(f.cnt));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one sample; returns #1 after the edge where it was accepted.
  task automatic send(input int k, input int v);
    bit ok = 0;
    in_valid_s[k] = 1'b1;
    in_data_s[k]  = DW'(v);
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (in_ready_s[k] && !flush_s[k]) begin
        ok = 1;
        model_accept(v);
      end
      @(posedge clk);
      #1;
    end
    if (!ok) check("send_timeout", FW'(in_ready_s[k]), FW'(1));
    in_valid_s[k] = 1'b0;
  endtask

  task automatic pulse_flush(input int k);
    flush_s[k] = 1'b1;
    cyc(1);
    flush_s[k] = 1'b0;
    model_flush();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NI; i++) begin
      flush_s[i] = 0; in_valid_s[i] = 0; in_data_s[i] = '0; frame_ready_s[i] = 1;
    end
    act = 0;
    model_init(16);
    rst = 1'b1;
    cyc(2);
    check("rst_valid", FW'(frame_valid_s[0]), '0);
    check("rst_ready", FW'(in_ready_s[0]), FW'(1));
    check("rst_cnt", FW'(frame_cnt_s[0]), '0);
    check("rst_data", frame_data_s[0], '0);
    rst = 1'b0;
    cyc(1);

    // HOP=DEPTH: first frame one cycle after sample 16
    for (int v = 1; v <= 16; v++) begin
      send(0, v);
      if (v == 15) check("fill_no_frame", FW'(frame_valid_s[0]), '0);
    end
    check("f1_valid", FW'(frame_valid_s[0]), FW'(1));
    check("f1_slot0", FW'(slot(frame_data_s[0], 0)), FW'(1));
    check("f1_slot15", FW'(slot(frame_data_s[0], 15)), FW'(16));
    check("f1_cnt", FW'(frame_cnt_s[0]), FW'(1));
    cyc(2);

    // Reset during FILL at sample 7: outputs clear immediately
    pulse_flush(0);
    for (int v = 1; v <= 7; v++) send(0, v);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", FW'(frame_valid_s[0]), '0);
    check("arst_data", frame_data_s[0], '0);
    check("arst_cnt", FW'(frame_cnt_s[0]), '0);
    check("arst_ready", FW'(in_ready_s[0]), FW'(1));
    model_init(16);
    cyc(2);
    rst = 1'b0;
    cyc(1);
    for (int v = 50; v < 66; v++) begin
      send(0, v);
      if (v == 64) check("arst_no_early", FW'(frame_valid_s[0]), '0);
    end
    check("arst_frame", FW'(frame_valid_s[0]), FW'(1));
    check("arst_frame_cnt", FW'(frame_cnt_s[0]), FW'(1));
    cyc(2);

    // Flush with in_valid after sample 10: sample dropped, 16 more needed
    pulse_flush(0);
    for (int v = 1; v <= 10; v++) send(0, v);
    flush_s[0] = 1'b1; in_valid_s[0] = 1'b1; in_data_s[0] = DW'(11);
    cyc(1);
    flush_s[0] = 1'b0; in_valid_s[0] = 1'b0;
    model_flush();
    check("flush_valid", FW'(frame_valid_s[0]), '0);
    check("flush_cnt_kept", FW'(frame_cnt_s[0]), FW'(1));
    for (int v = 200; v < 216; v++) begin
      send(0, v);
      if (v == 205 || v == 214) check("flush_no_early", FW'(frame_valid_s[0]), '0);
    end
    check("flush_frame", FW'(frame_valid_s[0]), FW'(1));
    check("flush_slot0", FW'(slot(frame_data_s[0], 0)), FW'(200));
    check("flush_slot15", FW'(slot(frame_data_s[0], 15)), FW'(215));
    cyc(2);

    // Slot ordering with samples 0..15
    pulse_flush(0);
    for (int v = 0; v < 16; v++) send(0, v);
`ifdef BITREV_OUT_EN
    check("ord_slot1", FW'(slot(frame_data_s[0], 1)), FW'(8));
    check("ord_slot2", FW'(slot(frame_data_s[0], 2)), FW'(4));
    check("ord_slot3", FW'(slot(frame_data_s[0], 3)), FW'(12));
`else
    check("ord_slot1", FW'(slot(frame_data_s[0], 1)), FW'(1));
    check("ord_slot2", FW'(slot(frame_data_s[0], 2)), FW'(2));
    check("ord_slot3", FW'(slot(frame_data_s[0], 3)), FW'(3));
`endif
    check("ord_slot15", FW'(slot(frame_data_s[0], 15)), FW'(15));
    cyc(2);
    check("drain0", FW'(exp_q.size()), '0);

    // HOP=4: frames on samples 16, 20, 24
    act = 1;
    model_init(4);
    for (int v = 1; v <= 24; v++) begin
      send(1, v);
      if (v == 19) check("hop4_gap", FW'(frame_valid_s[1]), '0);
      if (v == 20) begin
        check("hop4_f2_valid", FW'(frame_valid_s[1]), FW'(1));
        check("hop4_f2_slot0", FW'(slot(frame_data_s[1], 0)), FW'(5));
        check("hop4_f2_slot15", FW'(slot(frame_data_s[1], 15)), FW'(20));
      end
    end
    check("hop4_f3_valid", FW'(frame_valid_s[1]), FW'(1));
    check("hop4_f3_cnt", FW'(frame_cnt_s[1]), FW'(3));
    cyc(2);
    check("drain1", FW'(exp_q.size()), '0);

    // HOP=1 with a stalled consumer
    act = 2;
    model_init(1);
    frame_ready_s[2] = 1'b0;
    for (int v = 1; v <= 16; v++) send(2, v);
    check("hop1_f1_valid", FW'(frame_valid_s[2]), FW'(1));
    in_valid_s[2] = 1'b1; in_data_s[2] = DW'(17);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check("hop1_stall_ready", FW'(in_ready_s[2]), '0);
      check("hop1_hold_slot0", FW'(slot(frame_data_s[2], 0)), FW'(1));
    end
    @(posedge clk); #1;
    frame_ready_s[2] = 1'b1;
    send(2, 17);
    frame_ready_s[2] = 1'b0;
    check("hop1_f2_valid", FW'(frame_valid_s[2]), FW'(1));
    check("hop1_f2_slot0", FW'(slot(frame_data_s[2], 0)), FW'(2));
    check("hop1_f2_cnt", FW'(frame_cnt_s[2]), FW'(2));
    cyc(3);
    check("hop1_f2_held", FW'(frame_valid_s[2]), FW'(1));
    frame_ready_s[2] = 1'b1;
    cyc(2);
    check("hop1_after_take", FW'(frame_valid_s[2]), '0);
    check("drain2", FW'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
